midi_voice_ctrl: RTL

MIDI_VOICE_CTRL -- requirements
Module: midi_voice_ctrl

---
 rtl/midi_pkg.sv | 21 ++
 rtl/midi_note_fcw.sv | 28 ++
 rtl/midi_voice_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the voice controller: status byte constants,
// parser state encoding and a status-classification helper.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] SYS_BASE = 8'hF0;
    localparam logic [7:0] RT_BASE  = 8'hF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2
    } parse_state_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_data(input logic [7:0] status);
        return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    endfunction

endpackage

// File: rtl/midi_note_fcw.sv
// Note number to tone-generator frequency control word (48 kHz sample rate,
// 16-bit phase accumulator), with a registered read port.
module midi_note_fcw (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  addr_s,
    output logic [15:0] fcw_r
);

    logic [15:0] rom_s [128];

    // Equal-tempered table around A4 = 440 Hz (note 69), rounded to nearest.
    for (genvar g = 0; g < 128; g++) begin : g_rom
        localparam real FREQ     = 440.0 * (2.0 ** ((g - 69) / 12.0));
        localparam real FCW_REAL = FREQ * 65536.0 / 48000.0;
        assign rom_s[g] = 16'($rtoi(FCW_REAL + 0.5));
    end

    // Registered table lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fcw_r <= 16'd0;
        end else begin
            fcw_r <= rom_s[addr_s];
        end
    end

endmodule

// File: rtl/midi_voice_ctrl.sv
// Monophonic MIDI voice controller: parses a UART byte stream with running
// status and drives a tone generator (fcw, gate, note, velocity).
module midi_voice_ctrl
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ready,
    input  logic [7:0]  i_data_byte,
    output logic [15:0] o_fcw,
    output logic        o_gate,
    output logic [6:0]  o_note,
    output logic [6:0]  o_velocity,
    output logic        o_event
);

    parse_state_t state_r;
    logic [7:0]   rs_r;
    logic         rs_valid_r;
    logic [6:0]   data1_r;
    logic         pend_valid_r;
    logic         pend_on_r;
    logic [6:0]   pend_note_r;
    logic [6:0]   pend_vel_r;
    logic [15:0]  rom_fcw_s;
    logic         is_rt_s;
    logic         is_sys_s;
    logic         own_note_msg_s;
    logic         is_note_on_s;

    assign is_rt_s        = (i_data_byte >= RT_BASE);
    assign is_sys_s       = (i_data_byte >= SYS_BASE) && !is_rt_s;
    assign is_note_on_s   = (rs_r[7:4] == NOTE_ON[7:4]);
    assign own_note_msg_s = ((rs_r[7:4] == NOTE_OFF[7:4]) || is_note_on_s)
                            && (rs_r[3:0] == CHANNEL);

    // ROM address is the stored first data byte, so the lookup lands in the
    // same cycle as the pending action it belongs to.
    midi_note_fcw u_note_fcw (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .addr_s  (data1_r),
        .fcw_r   (rom_fcw_s)
    );

    // Byte parser with running status; emits one pending note action per message.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            rs_r         <= 8'd0;
            rs_valid_r   <= 1'b0;
            data1_r      <= 7'd0;
            pend_valid_r <= 1'b0;
            pend_on_r    <= 1'b0;
            pend_note_r  <= 7'd0;
            pend_vel_r   <= 7'd0;
        end else begin
            pend_valid_r <= 1'b0;
            if (i_ready && !is_rt_s) begin
                if (is_sys_s) begin
                    rs_valid_r <= 1'b0;
                    state_r    <= IDLE;
                end else if (i_data_byte[7]) begin
                    rs_r       <= i_data_byte;
                    rs_valid_r <= 1'b1;
                    state_r    <= DATA1;
                end else begin
                    case (state_r)
                        IDLE, DATA1: begin
                            if (rs_valid_r) begin
                                data1_r <= i_data_byte[6:0];
                                state_r <= is_one_data(rs_r) ? IDLE : DATA2;
                            end
                        end
                        DATA2: begin
                            state_r      <= IDLE;
                            pend_valid_r <= own_note_msg_s;
                            pend_on_r    <= is_note_on_s && (i_data_byte[6:0] != 7'd0);
                            pend_note_r  <= data1_r;
                            pend_vel_r   <= i_data_byte[6:0];
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

    // Voice state update; a release only affects the note currently sounding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fcw      <= 16'd0;
            o_gate     <= 1'b0;
            o_note     <= 7'd0;
            o_velocity <= 7'd0;
            o_event    <= 1'b0;
        end else begin
            o_event <= 1'b0;
            if (pend_valid_r) begin
                if (pend_on_r) begin
                    o_fcw      <= rom_fcw_s;
                    o_gate     <= 1'b1;
                    o_note     <= pend_note_r;
                    o_velocity <= pend_vel_r;
                    o_event    <= 1'b1;
                end else if (o_gate && (pend_note_r == o_note)) begin
                    o_gate  <= 1'b0;
                    o_event <= 1'b1;
                end
            end
        end
    end

endmodule
